usb2_ep_mux: RTL

//  Parametrised N-endpoint router between usb2_packet and per-endpoint buffers, in the phy_clk domain.

---
 rtl/usb2_ep_mux_pkg.sv | 27 ++
 rtl/usb2_ep_mux_toggle_bank.sv | 39 +++
 rtl/usb2_ep_mux.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb2_ep_mux_pkg.sv
// Shared definitions for the USB2 endpoint router: FSM state codes,
// endpoint mode codes, data toggle values and the select range check.
package usb2_ep_mux_pkg;

    localparam int SEL_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_COMMIT_WAIT = 3'd1,
        ST_ARM_WAIT    = 3'd2,
        ST_DONE        = 3'd3
    } ep_state_e;

    localparam logic [1:0] MODE_CTRL = 2'd0;
    localparam logic [1:0] MODE_BULK = 2'd1;
    localparam logic [1:0] MODE_INT  = 2'd2;
    localparam logic [1:0] MODE_ISO  = 2'd3;

    localparam logic DATA0 = 1'b0;
    localparam logic DATA1 = 1'b1;

    // True when an endpoint number addresses an existing channel
    function automatic logic ep_in_range(input logic [SEL_W-1:0] ep, input int num_ep);
        return ({28'd0, ep} < num_ep);
    endfunction

endpackage

// File: rtl/usb2_ep_mux_toggle_bank.sv
// Per-channel DATA0/DATA1 toggle bank. A flip request only affects the
// selected channel; a clear always wins over a flip on the same channel.
import usb2_ep_mux_pkg::*;

module usb2_ep_mux_toggle_bank #(
    parameter int NUM_EP = 4
) (
    input  logic              phy_clk,
    input  logic              reset_n,
    input  logic              act,
    input  logic [NUM_EP-1:0] act_sel,
    input  logic [NUM_EP-1:0] clr,
    output logic [NUM_EP-1:0] toggle
);

    logic [NUM_EP-1:0] toggle_q;
    logic [NUM_EP-1:0] toggle_d;

    // Next toggle per channel: clear to DATA0 first, else flip if selected
    always_comb begin
        toggle_d = toggle_q;
        for (int i = 0; i < NUM_EP; i++) begin
            toggle_d[i] = clr[i] ? DATA0
                                 : ((act && act_sel[i]) ? ~toggle_q[i] : toggle_q[i]);
        end
    end

    // Toggle flops, all channels start at DATA0
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q <= {NUM_EP{DATA0}};
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign toggle = toggle_q;

endmodule

// File: rtl/usb2_ep_mux.sv
// N-endpoint router between the packet layer and per-endpoint buffers.
// The channel select is latched only while idle; commit/arm requests are
// held to the channel until it acks or a timeout forces completion.
// Selects beyond NUM_EP are sunk so the packet layer never stalls.
import usb2_ep_mux_pkg::*;

module usb2_ep_mux #(
    parameter int NUM_EP      = 4,
    parameter int ADDR_W      = 9,
    parameter int LEN_W       = 10,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                    phy_clk,
    input  logic                    reset_n,
    input  logic [SEL_W-1:0]        sel_endp,
    input  logic [ADDR_W-1:0]       buf_in_addr,
    input  logic [7:0]              buf_in_data,
    input  logic                    buf_in_wren,
    output logic                    buf_in_ready,
    input  logic                    buf_in_commit,
    input  logic [LEN_W-1:0]        buf_in_commit_len,
    output logic                    buf_in_commit_ack,
    input  logic [ADDR_W-1:0]       buf_out_addr,
    output logic [7:0]              buf_out_q,
    output logic [LEN_W-1:0]        buf_out_len,
    output logic                    buf_out_hasdata,
    input  logic                    buf_out_arm,
    output logic                    buf_out_arm_ack,
    output logic [1:0]              endp_mode,
    input  logic                    data_toggle_act,
    output logic [1:0]              data_toggle,
    input  logic [NUM_EP-1:0]       toggle_clr,
    output logic [ADDR_W-1:0]       ch_buf_in_addr,
    output logic [7:0]              ch_buf_in_data,
    output logic [NUM_EP-1:0]       ch_buf_in_wren,
    input  logic [NUM_EP-1:0]       ch_buf_in_ready,
    output logic [NUM_EP-1:0]       ch_buf_in_commit,
    output logic [LEN_W-1:0]        ch_buf_in_commit_len,
    input  logic [NUM_EP-1:0]       ch_buf_in_commit_ack,
    output logic [ADDR_W-1:0]       ch_buf_out_addr,
    input  logic [NUM_EP*8-1:0]     ch_buf_out_q,
    input  logic [NUM_EP*LEN_W-1:0] ch_buf_out_len,
    input  logic [NUM_EP-1:0]       ch_buf_out_hasdata,
    output logic [NUM_EP-1:0]       ch_buf_out_arm,
    input  logic [NUM_EP-1:0]       ch_buf_out_arm_ack,
    input  logic [NUM_EP*2-1:0]     ch_endp_mode,
    output logic                    err_sel_invalid,
    output logic                    err_ack_timeout,
    output logic [2:0]              dbg_state
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(ACK_TIMEOUT);

    ep_state_e          state_q,       state_d;
    logic [SEL_W-1:0]   cur_ch_q,      cur_ch_d;
    logic               cur_valid_q,   cur_valid_d;
    logic [TMR_W-1:0]   timer_q,       timer_d;
    logic               commit_pend_q, commit_pend_d;
    logic               arm_pend_q,    arm_pend_d;
    logic [LEN_W-1:0]   pend_len_q,    pend_len_d;
    logic [LEN_W-1:0]   commit_len_q,  commit_len_d;
    logic [NUM_EP-1:0]  commit_req_q,  commit_req_d;
    logic [NUM_EP-1:0]  arm_req_q,     arm_req_d;
    logic               in_ack_q,      in_ack_d;
    logic               out_ack_q,     out_ack_d;
    logic               err_inv_q,     err_inv_d;
    logic               err_to_q,      err_to_d;

    logic [NUM_EP-1:0]  sel_oh_s;
    logic [NUM_EP-1:0]  toggle_s;
    logic               sel_ok_s;
    logic               want_commit_s;
    logic               want_arm_s;
    logic [TMR_W-1:0]   timer_inc_s;
    logic               ready_s;
    logic               hasdata_s;
    logic               tog_s;
    logic [7:0]         q_s;
    logic [LEN_W-1:0]   len_s;
    logic [1:0]         mode_s;

    // Channel decode and read-side muxes; an invalid channel selects nothing
    always_comb begin
        sel_oh_s  = {NUM_EP{1'b0}};
        ready_s   = 1'b0;
        hasdata_s = 1'b0;
        tog_s     = DATA0;
        q_s       = 8'd0;
        len_s     = {LEN_W{1'b0}};
        mode_s    = MODE_CTRL;
        for (int i = 0; i < NUM_EP; i++) begin
            sel_oh_s[i] = cur_valid_q && (cur_ch_q == SEL_W'(i));
            ready_s     = ready_s   | (ch_buf_in_ready[i]    & sel_oh_s[i]);
            hasdata_s   = hasdata_s | (ch_buf_out_hasdata[i] & sel_oh_s[i]);
            tog_s       = tog_s     | (toggle_s[i]           & sel_oh_s[i]);
            q_s         = q_s       | (ch_buf_out_q[i*8 +: 8] & {8{sel_oh_s[i]}});
            len_s       = len_s     | (ch_buf_out_len[i*LEN_W +: LEN_W] & {LEN_W{sel_oh_s[i]}});
            mode_s      = mode_s    | (ch_endp_mode[i*2 +: 2] & {2{sel_oh_s[i]}});
        end
    end

    // Handshake FSM next state: select latch, request hold, ack/timeout, pending requests
    always_comb begin
        state_d       = state_q;
        cur_ch_d      = cur_ch_q;
        cur_valid_d   = cur_valid_q;
        timer_d       = timer_q;
        commit_pend_d = commit_pend_q;
        arm_pend_d    = arm_pend_q;
        commit_len_d  = commit_len_q;
        commit_req_d  = commit_req_q;
        arm_req_d     = arm_req_q;
        in_ack_d      = 1'b0;
        out_ack_d     = 1'b0;
        err_inv_d     = 1'b0;
        err_to_d      = 1'b0;
        sel_ok_s      = ep_in_range(sel_endp, NUM_EP);
        want_commit_s = buf_in_commit | commit_pend_q;
        want_arm_s    = buf_out_arm | arm_pend_q;
        timer_inc_s   = timer_q + TMR_W'(1);
        // A commit arriving while busy keeps its length until it is serviced
        pend_len_d    = ((state_q != ST_IDLE) && buf_in_commit) ? buf_in_commit_len : pend_len_q;
        case (state_q)
            ST_IDLE: begin
                if (want_commit_s) begin
                    state_d       = ST_COMMIT_WAIT;
                    commit_req_d  = sel_oh_s;
                    commit_len_d  = buf_in_commit ? buf_in_commit_len : pend_len_q;
                    commit_pend_d = 1'b0;
                    arm_pend_d    = want_arm_s;
                    timer_d       = {TMR_W{1'b0}};
                end else if (want_arm_s) begin
                    state_d    = ST_ARM_WAIT;
                    arm_req_d  = sel_oh_s;
                    arm_pend_d = 1'b0;
                    timer_d    = {TMR_W{1'b0}};
                end else begin
                    // Select is only sampled while no handshake is starting
                    cur_ch_d    = sel_endp;
                    cur_valid_d = sel_ok_s;
                    err_inv_d   = !sel_ok_s && (sel_endp != cur_ch_q);
                end
            end
            ST_COMMIT_WAIT: begin
                commit_pend_d = commit_pend_q | buf_in_commit;
                arm_pend_d    = arm_pend_q | buf_out_arm;
                timer_d       = timer_inc_s;
                if (!cur_valid_q || ((ch_buf_in_commit_ack & sel_oh_s) != {NUM_EP{1'b0}})) begin
                    state_d      = ST_DONE;
                    commit_req_d = {NUM_EP{1'b0}};
                    in_ack_d     = 1'b1;
                end else if (timer_inc_s == TMR_LIMIT) begin
                    state_d      = ST_DONE;
                    commit_req_d = {NUM_EP{1'b0}};
                    in_ack_d     = 1'b1;
                    err_to_d     = 1'b1;
                end else begin
                    state_d = ST_COMMIT_WAIT;
                end
            end
            ST_ARM_WAIT: begin
                commit_pend_d = commit_pend_q | buf_in_commit;
                arm_pend_d    = arm_pend_q | buf_out_arm;
                timer_d       = timer_inc_s;
                if (!cur_valid_q || ((ch_buf_out_arm_ack & sel_oh_s) != {NUM_EP{1'b0}})) begin
                    state_d   = ST_DONE;
                    arm_req_d = {NUM_EP{1'b0}};
                    out_ack_d = 1'b1;
                end else if (timer_inc_s == TMR_LIMIT) begin
                    state_d   = ST_DONE;
                    arm_req_d = {NUM_EP{1'b0}};
                    out_ack_d = 1'b1;
                    err_to_d  = 1'b1;
                end else begin
                    state_d = ST_ARM_WAIT;
                end
            end
            ST_DONE: begin
                commit_pend_d = commit_pend_q | buf_in_commit;
                arm_pend_d    = arm_pend_q | buf_out_arm;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and handshake registers; reset drops every request immediately
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cur_ch_q      <= {SEL_W{1'b0}};
            cur_valid_q   <= 1'b1;
            timer_q       <= {TMR_W{1'b0}};
            commit_pend_q <= 1'b0;
            arm_pend_q    <= 1'b0;
            pend_len_q    <= {LEN_W{1'b0}};
            commit_len_q  <= {LEN_W{1'b0}};
            commit_req_q  <= {NUM_EP{1'b0}};
            arm_req_q     <= {NUM_EP{1'b0}};
            in_ack_q      <= 1'b0;
            out_ack_q     <= 1'b0;
            err_inv_q     <= 1'b0;
            err_to_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_ch_q      <= cur_ch_d;
            cur_valid_q   <= cur_valid_d;
            timer_q       <= timer_d;
            commit_pend_q <= commit_pend_d;
            arm_pend_q    <= arm_pend_d;
            pend_len_q    <= pend_len_d;
            commit_len_q  <= commit_len_d;
            commit_req_q  <= commit_req_d;
            arm_req_q     <= arm_req_d;
            in_ack_q      <= in_ack_d;
            out_ack_q     <= out_ack_d;
            err_inv_q     <= err_inv_d;
            err_to_q      <= err_to_d;
        end
    end

    usb2_ep_mux_toggle_bank #(
        .NUM_EP (NUM_EP)
    ) u_toggle_bank (
        .phy_clk (phy_clk),
        .reset_n (reset_n),
        .act     (data_toggle_act),
        .act_sel (sel_oh_s),
        .clr     (toggle_clr),
        .toggle  (toggle_s)
    );

    assign buf_in_ready         = ready_s;
    assign buf_out_q            = q_s;
    assign buf_out_len          = len_s;
    assign buf_out_hasdata      = hasdata_s;
    assign endp_mode            = mode_s;
    assign data_toggle          = {1'b0, tog_s};
    assign ch_buf_in_addr       = buf_in_addr;
    assign ch_buf_in_data       = buf_in_data;
    assign ch_buf_in_wren       = sel_oh_s & {NUM_EP{buf_in_wren}};
    assign ch_buf_out_addr      = buf_out_addr;
    assign ch_buf_in_commit     = commit_req_q;
    assign ch_buf_in_commit_len = commit_len_q;
    assign ch_buf_out_arm       = arm_req_q;
    assign buf_in_commit_ack    = in_ack_q;
    assign buf_out_arm_ack      = out_ack_q;
    assign err_sel_invalid      = err_inv_q;
    assign err_ack_timeout      = err_to_q;
    assign dbg_state            = state_q;

endmodule
